// File: rtl/vending_machine_change.sv
// Coin-operated vending controller with credit cap, single-cycle vend
// and unit-by-unit change/refund return.
module vending_machine_change #(
  parameter int PRICE      = 4,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic [1:0]          state,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_out,
  output logic                coin_reject,
  output logic                busy
);

  if (PRICE < 1 || PRICE > MAX_CREDIT ||
      MAX_CREDIT < 5 || MAX_CREDIT > 2**CREDIT_W-1) begin : g_bad_params
    $error("vending_machine_change: illegal PRICE/MAX_CREDIT/CREDIT_W");
  end

  localparam int SW = CREDIT_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    CHANGE  = 2'b11
  } st_t;

  st_t                 st_q, st_d;
  logic [CREDIT_W-1:0] cr_q, cr_d;
  logic                rej_q, rej_d;
  logic [SW-1:0]       value;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       price_w;
  logic [SW-1:0]       max_w;
  logic [CREDIT_W-1:0] price_c;
  logic                has_coin;

  assign price_w  = SW'(PRICE);
  assign max_w    = SW'(MAX_CREDIT);
  assign price_c  = CREDIT_W'(PRICE);
  assign has_coin = (coin != 2'b00);

  always_comb begin
    value = '0;
    unique case (coin)
      2'b00: value = SW'(0);
      2'b01: value = SW'(1);
      2'b10: value = SW'(2);
      2'b11: value = SW'(5);
    endcase
  end

  // one extra bit so the cap compare cannot wrap
  assign sum = {1'b0, cr_q} + value;

  always_comb begin
    st_d  = st_q;
    cr_d  = cr_q;
    rej_d = 1'b0;
    unique case (st_q)
      IDLE, COLLECT: begin
        if (st_q == COLLECT && cancel) begin
          st_d  = CHANGE;
          rej_d = has_coin;
        end else if (has_coin) begin
          if (sum <= max_w) begin
            cr_d = sum[CREDIT_W-1:0];
            st_d = (sum >= price_w) ? VEND : COLLECT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      VEND: begin
        cr_d  = cr_q - price_c;
        st_d  = (cr_q > price_c) ? CHANGE : IDLE;
        rej_d = has_coin;
      end
      CHANGE: begin
        rej_d = has_coin;
        if (cr_q <= CREDIT_W'(1)) begin
          cr_d = '0;
          st_d = IDLE;
        end else begin
          cr_d = cr_q - CREDIT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= IDLE;
      cr_q  <= '0;
      rej_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cr_q  <= cr_d;
      rej_q <= rej_d;
    end
  end

  assign state       = st_q;
  assign credit      = cr_q;
  assign coin_reject = rej_q;
  assign dispense    = (st_q == VEND);
  assign change_out  = (st_q == CHANGE);
  assign busy        = (st_q == VEND) || (st_q == CHANGE);

endmodule

// File: tb/tb_vending_machine_change.sv
// Scoreboard bench for vending_machine_change: default build plus a
// PRICE=10 / MAX_CREDIT=10 build.
`timescale 1ns/100ps
module tb_vending_machine_change;

  typedef struct {
    bit         sel;
    logic [1:0] st;
    logic [3:0] cr;
    logic [3:0] dcrb;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin1 = 2'b00, coin2 = 2'b00;
  logic       can1 = 1'b0, can2 = 1'b0;

  logic [1:0] st1, st2;
  logic [3:0] cr1, cr2;
  logic       d1, c1, r1, b1, d2, c2, r2, b2;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  vending_machine_change u_dut1 (
    .clk(clk), .reset(rst_n), .coin(coin1), .cancel(can1),
    .state(st1), .credit(cr1), .dispense(d1), .change_out(c1),
    .coin_reject(r1), .busy(b1)
  );

  vending_machine_change #(
    .PRICE(10), .CREDIT_W(4), .MAX_CREDIT(10)
  ) u_dut2 (
    .clk(clk), .reset(rst_n), .coin(coin2), .cancel(can2),
    .state(st2), .credit(cr2), .dispense(d2), .change_out(c2),
    .coin_reject(r2), .busy(b2)
  );

  task automatic check(input string nm, input logic [9:0] got,
                       input logic [9:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got st/cr/dcrb=%b actual, required %b",
               nm, got, exp);
    end
  endtask

  // monitor: each expected entry matches the outputs after one edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (!e.sel)
          check(e.nm, {st1, cr1, d1, c1, r1, b1},
                {e.st, e.cr, e.dcrb});
        else
          check(e.nm, {st2, cr2, d2, c2, r2, b2},
                {e.st, e.cr, e.dcrb});
      end
    end
  end

  task automatic apply(input bit sel, input logic [1:0] cn,
                       input logic cc, input logic [1:0] est,
                       input int ecr, input logic [3:0] edcrb,
                       input string nm);
    exp_t e;
    @(negedge clk);
    coin1 = sel ? 2'b00 : cn;
    can1  = sel ? 1'b0 : cc;
    coin2 = sel ? cn : 2'b00;
    can2  = sel ? cc : 1'b0;
    e.sel  = sel;
    e.st   = est;
    e.cr   = 4'(ecr);
    e.dcrb = edcrb;
    e.nm   = nm;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst1", {st1, cr1, d1, c1, r1, b1}, 10'b0);
    check("rst2", {st2, cr2, d2, c2, r2, b2}, 10'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1,1,2 -> exact price, no change
    apply(0, 2'b01, 0, 2'b01, 1, 4'b0000, "a_c1");
    apply(0, 2'b01, 0, 2'b01, 2, 4'b0000, "a_c2");
    apply(0, 2'b10, 0, 2'b10, 4, 4'b1001, "a_vend");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "a_idle");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "a_idle2");

    // 5 -> vend, one unit change
    apply(0, 2'b11, 0, 2'b10, 5, 4'b1001, "b_vend");
    apply(0, 2'b00, 0, 2'b11, 1, 4'b0101, "b_chg");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "b_idle");

    // 1,2 then cancel -> three refund pulses
    apply(0, 2'b01, 0, 2'b01, 1, 4'b0000, "c_c1");
    apply(0, 2'b10, 0, 2'b01, 3, 4'b0000, "c_c3");
    apply(0, 2'b00, 1, 2'b11, 3, 4'b0101, "c_can");
    apply(0, 2'b00, 0, 2'b11, 2, 4'b0101, "c_r2");
    apply(0, 2'b00, 0, 2'b11, 1, 4'b0101, "c_r1");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "c_idle");

    // coin during CHANGE is refused, change count intact
    apply(0, 2'b01, 0, 2'b01, 1, 4'b0000, "d_c1");
    apply(0, 2'b01, 0, 2'b01, 2, 4'b0000, "d_c2");
    apply(0, 2'b11, 0, 2'b10, 7, 4'b1001, "d_vend");
    apply(0, 2'b00, 0, 2'b11, 3, 4'b0101, "d_h3");
    apply(0, 2'b11, 0, 2'b11, 2, 4'b0111, "d_h2rej");
    apply(0, 2'b00, 0, 2'b11, 1, 4'b0101, "d_h1");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "d_idle");

    // cancel with coin in COLLECT: cancel wins, coin refused
    apply(0, 2'b01, 0, 2'b01, 1, 4'b0000, "e_c1");
    apply(0, 2'b01, 1, 2'b11, 1, 4'b0111, "e_canrej");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "e_idle");

    // cancel ignored in IDLE and VEND
    apply(0, 2'b00, 1, 2'b00, 0, 4'b0000, "f_idlecan");
    apply(0, 2'b11, 1, 2'b10, 5, 4'b1001, "f_vend");
    apply(0, 2'b00, 1, 2'b11, 1, 4'b0101, "f_vendcan");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "f_idle");

    // PRICE=10 / MAX=10: overflow refusal then exact fill
    apply(1, 2'b11, 0, 2'b01, 5, 4'b0000, "g_c5");
    apply(1, 2'b10, 0, 2'b01, 7, 4'b0000, "g_c7");
    apply(1, 2'b10, 0, 2'b01, 9, 4'b0000, "g_c9");
    apply(1, 2'b10, 0, 2'b01, 9, 4'b0010, "g_rej");
    apply(1, 2'b01, 0, 2'b10, 10, 4'b1001, "g_vend");
    apply(1, 2'b00, 0, 2'b00, 0, 4'b0000, "g_idle");

    // async reset in the middle of CHANGE
    apply(0, 2'b01, 0, 2'b01, 1, 4'b0000, "h_c1");
    apply(0, 2'b11, 0, 2'b10, 6, 4'b1001, "h_vend");
    apply(0, 2'b00, 0, 2'b11, 2, 4'b0101, "h_h2");
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check("h_async", {st1, cr1, d1, c1, r1, b1}, 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "h_post1");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "h_post2");
    apply(0, 2'b01, 0, 2'b01, 1, 4'b0000, "h_first");
    apply(0, 2'b00, 1, 2'b11, 1, 4'b0101, "h_can");
    apply(0, 2'b00, 0, 2'b00, 0, 4'b0000, "h_idle");

    begin
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      #5;
      if (q.size() > 0) begin
        nvec++;
        nbad++;
        $display("FAIL drain: %0d entries left, required 0", q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/vending_machine_change.md
VENDING_MACHINE_CHANGE -- requirements
Module: vending_machine_change

Interface
REQ-001 SHALL expose parameter PRICE, default 4: item price in credit units, legal range 1..MAX_CREDIT.
REQ-002 SHALL expose parameter CREDIT_W, default 4: width of the credit register and the credit output.
REQ-003 SHALL expose parameter MAX_CREDIT, default 12: credit cap, with MAX_CREDIT >= 5 and MAX_CREDIT <= 2**CREDIT_W-1.
REQ-004 SHALL fail elaboration if any constraint in REQ-001 or REQ-003 is violated.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 coin  input  2  coin inserted this cycle: 00 = none, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
REQ-008 cancel  input  1  level-sampled request to abort the purchase and refund the credit.
REQ-009 state  output  2  FSM state: IDLE=00, COLLECT=01, VEND=10, CHANGE=11.
REQ-010 credit  output  CREDIT_W  current credit held, in units.
REQ-011 dispense  output  1  high for exactly the one cycle the FSM is in VEND.
REQ-012 change_out  output  1  one-cycle pulse per unit of change or refund returned.
REQ-013 coin_reject  output  1  registered one-cycle pulse: the coin sampled on the previous edge was refused.
REQ-014 busy  output  1  high while state is VEND or CHANGE.

Function
REQ-015 Coins SHALL be sampled on the rising edge of clk; coin=00 is never accepted and never rejected.
REQ-016 In IDLE or COLLECT, coin SHALL be accepted if credit+value <= MAX_CREDIT, giving credit_next = credit+value.
REQ-017 If credit+value > MAX_CREDIT, credit and state SHALL be unchanged, and coin_reject SHALL be 1 in the following cycle.
REQ-018 On an accepted coin, next state SHALL be VEND if credit_next >= PRICE, else COLLECT.
REQ-019 The credit and sum arithmetic SHALL be at least CREDIT_W+1 bits wide, so the overflow compare never wraps.
REQ-020 IDLE: credit SHALL be 0; cancel is ignored.
REQ-021 COLLECT + cancel=1: next state SHALL be CHANGE with credit unchanged.
- A coin presented in the same cycle as cancel is refused (coin_reject pulse).
- Cancel has priority over the coin.
REQ-022 VEND SHALL last exactly one cycle.
- Credit is updated to credit-PRICE on exit.
- Next state is CHANGE if credit-PRICE > 0, else IDLE.
REQ-023 CHANGE: each cycle SHALL assert change_out and decrement credit by 1; the state leaves CHANGE for IDLE on the edge where credit goes from 1 to 0.
- Exactly N change_out pulses are issued for a remainder or refund of N.
REQ-024 Any non-zero coin sampled in VEND or CHANGE SHALL be refused with a coin_reject pulse; cancel SHALL be ignored in VEND and CHANGE.
REQ-025 dispense, change_out and busy SHALL be decoded from the state register only, with no input-to-output combinational path.
REQ-026 The end-to-end timing SHALL be as follows for a coin that completes the price on edge k:
- VEND in cycle k..k+1, with dispense high.
- First change_out at edge k+1, if any change is due.

Reset
REQ-027 While reset=0, all outputs SHALL be driven to their reset values immediately, independent of clk:
- state=IDLE
- credit=0
- dispense=0
- change_out=0
- coin_reject=0
- busy=0
REQ-028 Reset asserted mid-COLLECT, VEND or CHANGE SHALL discard the credit and any pending change, with no further change_out pulses.
REQ-029 The first rising edge after reset returns to 1 SHALL sample coin and cancel normally.

Verification (defaults unless stated)
REQ-030 Coins 01,01,10 on consecutive edges -> credit 1,2,4 -> one dispense cycle -> IDLE, credit 0, zero change_out pulses.
REQ-031 Coin 11 from IDLE -> credit 5 -> VEND (dispense 1 cycle) -> credit 1, CHANGE -> one change_out pulse -> IDLE.
REQ-032 Coins 01,10 then cancel=1 -> CHANGE, three change_out pulses, credit 3->0, dispense never asserted.
REQ-033 PRICE=10, MAX_CREDIT=10; coins 11,10,10,10 -> credit 5,7,9,9 with coin_reject on the 4th -> coin 01 -> credit 10, dispense, IDLE, no change.
REQ-034 Run two sub-cases:
- Coin 11 during CHANGE -> coin_reject pulse, change count unaffected.
- cancel and coin 01 on the same edge in COLLECT -> CHANGE entered, coin rejected, credit unchanged.
REQ-035 Coin 11 then reset=0 asynchronously during CHANGE -> all outputs 0 before the next edge; after release, no residual change_out.
